// File: rtl/mac_fp_mx_dot.sv
// Multi-lane ExMy dot-product MAC: exact per-beat lane sums accumulated over a block
// into a saturating signed result, emitted with the block's shared scale.
module mac_fp_mx_dot #(
  parameter int unsigned EXP_WIDTH   = 2,
  parameter int unsigned MAN_WIDTH   = 1,
  parameter int unsigned LANES       = 4,
  parameter int unsigned BLOCK_LEN   = 8,
  parameter int unsigned ACC_WIDTH   = 20,
  parameter int unsigned SCALE_WIDTH = 8
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [LANES*(1+EXP_WIDTH+MAN_WIDTH)-1:0] w_data,
  input  logic [LANES*(1+EXP_WIDTH+MAN_WIDTH)-1:0] a_data,
  input  logic [SCALE_WIDTH-1:0]                   in_scale,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [ACC_WIDTH-1:0]                     out_data,
  output logic [SCALE_WIDTH-1:0]                   out_scale,
  output logic                                     out_ovf
);

  localparam int unsigned EW = 1 + EXP_WIDTH + MAN_WIDTH;
  localparam int unsigned FW = MAN_WIDTH + 1;
  localparam int unsigned PW = 2 * FW + 2 * ((1 << EXP_WIDTH) - 2);
  localparam int unsigned SW = PW + 1 + $clog2(LANES);
  localparam int unsigned XW = ((ACC_WIDTH > SW) ? ACC_WIDTH : SW) + 1;
  localparam int unsigned BW = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;

  localparam logic signed [XW-1:0] ACC_MAX = {{(XW-ACC_WIDTH+1){1'b0}}, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [XW-1:0] ACC_MIN = {{(XW-ACC_WIDTH+1){1'b1}}, {(ACC_WIDTH-1){1'b0}}};

  // Exact unsigned product magnitude of one weight/activation pair.
  function automatic logic [PW-1:0] lane_mag(input logic [EW-1:0] w, input logic [EW-1:0] a);
    logic [EXP_WIDTH-1:0] ew, ea;
    logic [FW-1:0]        fw, fa;
    logic [EXP_WIDTH:0]   sw, sa, sh;
    logic [PW-1:0]        prod;
    ew   = w[EW-2 -: EXP_WIDTH];
    ea   = a[EW-2 -: EXP_WIDTH];
    fw   = {(ew != '0), w[MAN_WIDTH-1:0]};
    fa   = {(ea != '0), a[MAN_WIDTH-1:0]};
    sw   = (ew == '0) ? '0 : {1'b0, ew} - (EXP_WIDTH+1)'(1);
    sa   = (ea == '0) ? '0 : {1'b0, ea} - (EXP_WIDTH+1)'(1);
    sh   = sw + sa;
    prod = PW'(fw) * PW'(fa);
    return prod << sh;
  endfunction

  logic                          adv;
  logic                          s1_valid_q, s1_last_q, s2_valid_q, s2_last_q;
  logic [LANES*EW-1:0]           s1_w_q, s1_a_q;
  logic [SCALE_WIDTH-1:0]        s1_scale_q, s2_scale_q, blk_scale_q;
  logic [BW-1:0]                 beat_q;
  logic signed [SW-1:0]          lane_sum, s2_sum_q;
  logic [PW-1:0]                 mag;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_sat;
  logic signed [XW-1:0]          acc_sum;
  logic                          ovf_sticky_q, clamp;

  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  always_comb begin
    lane_sum = '0;
    mag      = '0;
    for (int i = 0; i < int'(LANES); i++) begin
      mag = lane_mag(s1_w_q[i*EW +: EW], s1_a_q[i*EW +: EW]);
      if (s1_w_q[i*EW+EW-1] ^ s1_a_q[i*EW+EW-1]) lane_sum = lane_sum - SW'(mag);
      else lane_sum = lane_sum + SW'(mag);
    end
  end

  // Clamp at every step so the sticky flag reflects any intermediate overflow.
  always_comb begin
    acc_sum = XW'(acc_q) + XW'(s2_sum_q);
    clamp   = 1'b0;
    acc_sat = ACC_WIDTH'(acc_sum);
    if (acc_sum > ACC_MAX) begin
      acc_sat = ACC_MAX[ACC_WIDTH-1:0];
      clamp   = 1'b1;
    end else if (acc_sum < ACC_MIN) begin
      acc_sat = ACC_MIN[ACC_WIDTH-1:0];
      clamp   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q   <= 1'b0;
      s1_last_q    <= 1'b0;
      s1_w_q       <= '0;
      s1_a_q       <= '0;
      s1_scale_q   <= '0;
      blk_scale_q  <= '0;
      beat_q       <= '0;
      s2_valid_q   <= 1'b0;
      s2_last_q    <= 1'b0;
      s2_sum_q     <= '0;
      s2_scale_q   <= '0;
      acc_q        <= '0;
      ovf_sticky_q <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_scale    <= '0;
      out_ovf      <= 1'b0;
    end else if (adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_w_q     <= w_data;
        s1_a_q     <= a_data;
        s1_last_q  <= (beat_q == BW'(BLOCK_LEN - 1));
        s1_scale_q <= (beat_q == '0) ? in_scale : blk_scale_q;
        if (beat_q == '0) blk_scale_q <= in_scale;
        beat_q <= (beat_q == BW'(BLOCK_LEN - 1)) ? '0 : beat_q + BW'(1);
      end
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sum_q   <= lane_sum;
        s2_last_q  <= s1_last_q;
        s2_scale_q <= s1_scale_q;
      end
      // With adv high any pending result is being consumed on this edge.
      out_valid <= s2_valid_q && s2_last_q;
      if (s2_valid_q) begin
        if (s2_last_q) begin
          out_data     <= acc_sat;
          out_ovf      <= ovf_sticky_q | clamp;
          out_scale    <= s2_scale_q;
          acc_q        <= '0;
          ovf_sticky_q <= 1'b0;
        end else begin
          acc_q        <= acc_sat;
          ovf_sticky_q <= ovf_sticky_q | clamp;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_fp_mx_dot.sv
// Bench for mac_fp_mx_dot: four instances (default, BLOCK_LEN=2, BLOCK_LEN=1, narrow
// accumulator) checked against an FP4 value-table reference model.
module tb_mac_fp_mx_dot;

  typedef struct {
    int         data;
    logic [7:0] scale;
    bit         ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] w_data = '0, a_data = '0;
  logic [7:0]  in_scale = '0;

  logic in_valid_a = 0, in_valid_b = 0, in_valid_c = 0, in_valid_d = 0;
  logic out_ready_a = 1, out_ready_b = 1, out_ready_c = 1, out_ready_d = 1;
  logic in_ready_a, in_ready_b, in_ready_c, in_ready_d;
  logic out_valid_a, out_valid_b, out_valid_c, out_valid_d;
  logic out_ovf_a, out_ovf_b, out_ovf_c, out_ovf_d;
  logic [19:0] out_data_a, out_data_b, out_data_c;
  logic [9:0]  out_data_d;
  logic [7:0]  out_scale_a, out_scale_b, out_scale_c, out_scale_d;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_fp_mx_dot dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .w_data(w_data), .a_data(a_data), .in_scale(in_scale), .out_valid(out_valid_a),
    .out_ready(out_ready_a), .out_data(out_data_a), .out_scale(out_scale_a), .out_ovf(out_ovf_a)
  );

  mac_fp_mx_dot #(.BLOCK_LEN(2)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .w_data(w_data), .a_data(a_data), .in_scale(in_scale), .out_valid(out_valid_b),
    .out_ready(out_ready_b), .out_data(out_data_b), .out_scale(out_scale_b), .out_ovf(out_ovf_b)
  );

  mac_fp_mx_dot #(.BLOCK_LEN(1)) dut_c (
    .clk(clk), .reset(reset), .in_valid(in_valid_c), .in_ready(in_ready_c),
    .w_data(w_data), .a_data(a_data), .in_scale(in_scale), .out_valid(out_valid_c),
    .out_ready(out_ready_c), .out_data(out_data_c), .out_scale(out_scale_c), .out_ovf(out_ovf_c)
  );

  mac_fp_mx_dot #(.ACC_WIDTH(10), .BLOCK_LEN(2)) dut_d (
    .clk(clk), .reset(reset), .in_valid(in_valid_d), .in_ready(in_ready_d),
    .w_data(w_data), .a_data(a_data), .in_scale(in_scale), .out_valid(out_valid_d),
    .out_ready(out_ready_d), .out_data(out_data_d), .out_scale(out_scale_d), .out_ovf(out_ovf_d)
  );

  // FP4 E2M1 element value in units of 0.5, so a product is in units of 0.25.
  function automatic int elem2(input logic [3:0] e);
    int m;
    case (e[2:0])
      3'd0: m = 0;
      3'd1: m = 1;
      3'd2: m = 2;
      3'd3: m = 3;
      3'd4: m = 4;
      3'd5: m = 6;
      3'd6: m = 8;
      default: m = 12;
    endcase
    return e[3] ? -m : m;
  endfunction

  function automatic int beat_sum(input logic [15:0] w, input logic [15:0] a);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) s += elem2(w[i*4 +: 4]) * elem2(a[i*4 +: 4]);
    return s;
  endfunction

  function automatic int sat_add(input int x, input int y, input int aw, output bit c);
    int hi, lo, t;
    hi = (1 << (aw - 1)) - 1;
    lo = -(1 << (aw - 1));
    t  = x + y;
    c  = 1'b0;
    if (t > hi) begin
      t = hi;
      c = 1'b1;
    end else if (t < lo) begin
      t = lo;
      c = 1'b1;
    end
    return t;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready_a); end
    checks++; if (out_valid_a !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid_a); end
    checks++; if (out_data_a !== 20'd0) begin errors++; $display("FAIL reset_out_data: got %0h want 0", out_data_a); end
    checks++; if (out_scale_a !== 8'd0) begin errors++; $display("FAIL reset_out_scale: got %0h want 0", out_scale_a); end
    checks++; if (out_ovf_a !== 1'b0) begin errors++; $display("FAIL reset_out_ovf: got %b want 0", out_ovf_a); end
    checks++; if ({out_valid_b, out_valid_c, out_valid_d} !== 3'b000) begin
      errors++; $display("FAIL reset_other_valid: got %b want 000", {out_valid_b, out_valid_c, out_valid_d});
    end
    out_ready_a = 1'b0;
    #1;
    checks++; if (in_ready_a !== 1'b1) begin errors++; $display("FAIL reset_in_ready_no_pending: got %b want 1", in_ready_a); end
    out_ready_a = 1'b1;
  endtask

  task automatic test_basic();
    int exp_d;
    exp_d = 2 * beat_sum(16'h7777, 16'h7777);
    @(negedge clk);
    w_data = 16'h7777; a_data = 16'h7777; in_scale = 8'h7F; in_valid_b = 1'b1;
    @(negedge clk);
    in_scale = 8'h15;  // must be ignored: not the first beat
    @(negedge clk);
    in_valid_b = 1'b0;
    #1;
    checks++; if (out_valid_b !== 1'b0) begin errors++; $display("FAIL basic_valid_k: got %b want 0", out_valid_b); end
    @(negedge clk); #1;
    checks++; if (out_valid_b !== 1'b0) begin errors++; $display("FAIL basic_valid_k1: got %b want 0", out_valid_b); end
    @(negedge clk); #1;
    checks++; if (out_valid_b !== 1'b1) begin errors++; $display("FAIL basic_valid_k2: got %b want 1", out_valid_b); end
    checks++; if (out_data_b !== 20'(exp_d)) begin errors++; $display("FAIL basic_data: got %0d want %0d", $signed(out_data_b), exp_d); end
    checks++; if (out_scale_b !== 8'h7F) begin errors++; $display("FAIL basic_scale: got %0h want 7f", out_scale_b); end
    checks++; if (out_ovf_b !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b want 0", out_ovf_b); end
    @(negedge clk); #1;
    checks++; if (out_valid_b !== 1'b0) begin errors++; $display("FAIL basic_consumed: got %b want 0", out_valid_b); end
  endtask

  task automatic test_sign_mix();
    int exp_d;
    exp_d = beat_sum(16'h821F, 16'h3217);
    @(negedge clk);
    w_data = 16'h821F; a_data = 16'h3217; in_scale = 8'h42; in_valid_c = 1'b1;
    @(negedge clk);
    in_valid_c = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (out_valid_c !== 1'b1) begin errors++; $display("FAIL sign_mix_valid: got %b want 1", out_valid_c); end
    checks++; if (out_data_c !== 20'(exp_d)) begin errors++; $display("FAIL sign_mix_data: got %0d want %0d", $signed(out_data_c), exp_d); end
    checks++; if (out_scale_c !== 8'h42) begin errors++; $display("FAIL sign_mix_scale: got %0h want 42", out_scale_c); end
  endtask

  task automatic test_back_to_back();
    int q[$];
    int e;
    out_ready_c = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid_c = (i < 6);
      w_data = 16'($urandom); a_data = 16'($urandom);
      #1;
      if (in_valid_c && in_ready_c) q.push_back(beat_sum(w_data, a_data));
      if (i >= 3 && i < 9) begin
        checks++; if (out_valid_c !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid_c); end
        if (q.size() > 0) begin
          e = q.pop_front();
          checks++; if (out_data_c !== 20'(e)) begin errors++; $display("FAIL b2b_data[%0d]: got %0d want %0d", i, $signed(out_data_c), e); end
        end
      end
    end
    checks++; if (out_valid_c !== 1'b0) begin errors++; $display("FAIL b2b_drain: got %b want 0", out_valid_c); end
    in_valid_c = 1'b0;
  endtask

  task automatic test_backpressure();
    int q[$];
    int n_in, n_out, e;
    bit stall;
    n_in = 0; n_out = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      stall = (i >= 10 && i < 13);
      in_valid_c = (i < 25);
      out_ready_c = !stall;
      w_data = 16'($urandom); a_data = 16'($urandom);
      #1;
      if (stall) begin
        checks++; if (in_ready_c !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready_c); end
        checks++; if (out_valid_c !== 1'b1) begin errors++; $display("FAIL bp_pending[%0d]: got %b want 1", i, out_valid_c); end
        if (q.size() > 0) begin
          checks++; if (out_data_c !== 20'(q[0])) begin errors++; $display("FAIL bp_hold[%0d]: got %0d want %0d", i, $signed(out_data_c), q[0]); end
        end
      end
      if (in_valid_c && in_ready_c) begin
        q.push_back(beat_sum(w_data, a_data));
        n_in++;
      end
      if (out_valid_c && out_ready_c) begin
        n_out++;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL bp_extra: got result %0d want none", $signed(out_data_c));
        end else begin
          e = q.pop_front();
          if (out_data_c !== 20'(e)) begin errors++; $display("FAIL bp_data: got %0d want %0d", $signed(out_data_c), e); end
        end
      end
    end
    in_valid_c = 1'b0; out_ready_c = 1'b1;
    checks++; if (n_out !== n_in || q.size() != 0) begin
      errors++; $display("FAIL bp_count: got %0d results want %0d", n_out, n_in);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] ws[6], as_[6];
    logic [7:0]  sc[6];
    res_t        exp_q[$];
    res_t        r;
    int          acc, n;
    bit          ov, c;
    ws  = '{16'h7777, 16'h7777, 16'h2222, 16'h0000, 16'hFFFF, 16'hFFFF};
    as_ = '{16'h7777, 16'h7777, 16'h2222, 16'h0000, 16'h7777, 16'h7777};
    sc  = '{8'h11, 8'hEE, 8'h22, 8'hDD, 8'h33, 8'hCC};
    acc = 0; ov = 0;
    for (int b = 0; b < 6; b++) begin
      acc = sat_add(acc, beat_sum(ws[b], as_[b]), 10, c);
      ov |= c;
      if (b % 2 == 1) begin
        r.data = acc; r.scale = sc[b-1]; r.ovf = ov;
        exp_q.push_back(r);
        acc = 0; ov = 0;
      end
    end
    n = 0;
    out_ready_d = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_valid_d = (i < 6);
      if (i < 6) begin
        w_data = ws[i]; a_data = as_[i]; in_scale = sc[i];
      end
      #1;
      if (out_valid_d) begin
        n++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL sat_extra: got %0d want none", $signed(out_data_d));
        end else begin
          r = exp_q.pop_front();
          if (out_data_d !== 10'(r.data) || out_ovf_d !== r.ovf || out_scale_d !== r.scale) begin
            errors++;
            $display("FAIL sat_result: got %0d/ovf=%b/scale=%0h want %0d/ovf=%b/scale=%0h",
                     $signed(out_data_d), out_ovf_d, out_scale_d, r.data, r.ovf, r.scale);
          end
        end
      end
    end
    in_valid_d = 1'b0;
    checks++; if (n != 3) begin errors++; $display("FAIL sat_count: got %0d want 3", n); end
  endtask

  task automatic test_mid_reset();
    int n, first, exp_d;
    exp_d = 8 * beat_sum(16'h2222, 16'h2222);
    out_ready_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      w_data = 16'h7777; a_data = 16'h7777; in_scale = 8'h99; in_valid_a = 1'b1;
    end
    @(negedge clk);
    in_valid_a = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n = 0; first = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      in_valid_a = (i < 8);
      w_data = 16'h2222; a_data = 16'h2222; in_scale = (i == 0) ? 8'h5A : 8'hA5;
      #1;
      if (out_valid_a) begin
        if (n == 0) first = $signed(out_data_a);
        n++;
      end
    end
    in_valid_a = 1'b0;
    checks++; if (n != 1) begin errors++; $display("FAIL mid_reset_count: got %0d want 1", n); end
    checks++; if (first != exp_d) begin errors++; $display("FAIL mid_reset_data: got %0d want %0d", first, exp_d); end
    checks++; if (out_scale_a !== 8'h5A) begin errors++; $display("FAIL mid_reset_scale: got %0h want 5a", out_scale_a); end
  endtask

  task automatic test_random_stream();
    res_t q[$];
    res_t r, e;
    int   beat_idx, acc, n_res, n_exp;
    bit   ov, c;
    logic [7:0] blk_scale;
    beat_idx = 0; acc = 0; ov = 0; n_res = 0; n_exp = 0; blk_scale = '0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      @(negedge clk);
      if (cyc >= 400 && beat_idx == 0 && q.size() == 0) break;
      in_valid_a  = (cyc < 400 || beat_idx != 0) ? ($urandom_range(0, 9) < 7) : 1'b0;
      out_ready_a = (cyc < 400) ? ($urandom_range(0, 9) < 6) : 1'b1;
      w_data = 16'($urandom); a_data = 16'($urandom); in_scale = 8'($urandom);
      #1;
      if (in_valid_a && in_ready_a) begin
        if (beat_idx == 0) blk_scale = in_scale;
        acc = sat_add(acc, beat_sum(w_data, a_data), 20, c);
        ov |= c;
        beat_idx++;
        if (beat_idx == 8) begin
          r.data = acc; r.scale = blk_scale; r.ovf = ov;
          q.push_back(r);
          n_exp++;
          acc = 0; ov = 0; beat_idx = 0;
        end
      end
      if (out_valid_a && out_ready_a) begin
        n_res++;
        checks++;
        if (q.size() == 0) begin
          errors++; $display("FAIL rand_extra: got %0d want none", $signed(out_data_a));
        end else begin
          e = q.pop_front();
          if (out_data_a !== 20'(e.data) || out_scale_a !== e.scale || out_ovf_a !== e.ovf) begin
            errors++;
            $display("FAIL rand_result: got %0d/scale=%0h/ovf=%b want %0d/scale=%0h/ovf=%b",
                     $signed(out_data_a), out_scale_a, out_ovf_a, e.data, e.scale, e.ovf);
          end
        end
      end
    end
    in_valid_a = 1'b0; out_ready_a = 1'b1;
    checks++; if (q.size() != 0 || n_res != n_exp || n_exp == 0) begin
      errors++; $display("FAIL rand_count: got %0d results want %0d", n_res, n_exp);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign_mix();
    test_back_to_back();
    test_backpressure();
    test_saturation();
    test_mid_reset();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
